// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: FSM state encoding and
// the elaboration-time WIDTH/DIGIT divisibility check macro.
`ifndef SERIAL_SUBTRACTOR_PKG_SV
`define SERIAL_SUBTRACTOR_PKG_SV

// Elaboration fails if the operand width is not a whole number of digits.
`define SERSUB_CHECK_DIV(W, D) \
    generate \
        if ((((W) % (D)) != 0) || ((D) < 1) || ((D) > (W))) begin : g_bad_digit \
            $error("serial_subtractor: WIDTH must be a multiple of DIGIT and 1 <= DIGIT <= WIDTH"); \
        end \
    endgenerate

package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } sersub_state_t;

endpackage

`endif

// File: rtl/serial_subtractor_digit.sv
// Combinational DIGIT-bit ripple of 1-bit full-subtractor cells (module digit_subtractor).
// bo_msb_in exposes the borrow entering the top bit for signed-overflow detection.
module digit_subtractor #(
    parameter int DIGIT = 2
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             bi,
    output logic [DIGIT-1:0] d,
    output logic             bo,
    output logic             bo_msb_in
);

    logic [DIGIT:0] brw;

    assign brw[0] = bi;

    genvar i;
    generate
        for (i = 0; i < DIGIT; i++) begin : g_cell
            assign d[i]       = a[i] ^ b[i] ^ brw[i];
            assign brw[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
        end
    endgenerate

    assign bo        = brw[DIGIT];
    assign bo_msb_in = brw[DIGIT-1];

endmodule

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - bo_in, DIGIT bits per clock, LSB first.
// Optional feature macro: SERSUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bo_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bo_out
`ifdef SERSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NDIG  = WIDTH / DIGIT;
    localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIG - 1);

    `SERSUB_CHECK_DIV(WIDTH, DIGIT)

    sersub_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [WIDTH-1:0] diff_shift;
    logic             brw;
    logic             last_dig;

    logic [DIGIT-1:0] dig_d;
    logic             dig_bo;
    logic             dig_bo_msb;

    digit_subtractor #(.DIGIT(DIGIT)) u_digit (
        .a         (a_sh[DIGIT-1:0]),
        .b         (b_sh[DIGIT-1:0]),
        .bi        (brw),
        .d         (dig_d),
        .bo        (dig_bo),
        .bo_msb_in (dig_bo_msb)
    );

    // Each new digit enters at the MSB end so the LSB digit lands at bit 0 after NDIG shifts.
    generate
        if (NDIG == 1) begin : g_one_digit
            assign diff_shift = dig_d;
        end else begin : g_multi_digit
            assign diff_shift = {dig_d, diff[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign last_dig  = (cnt == CNT_LAST);
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            ST_RUN:  if (last_dig) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            brw    <= 1'b0;
            diff   <= '0;
            bo_out <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh <= a;
                        b_sh <= b;
                        brw  <= bo_in;
                        cnt  <= '0;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_sh >> DIGIT;
                    b_sh <= b_sh >> DIGIT;
                    diff <= diff_shift;
                    brw  <= dig_bo;
                    cnt  <= cnt + CNT_W'(1);
                    if (last_dig) begin
                        bo_out <= dig_bo;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SERSUB_OVF_EN
    // Signed overflow: borrow into the sign bit disagrees with borrow out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if ((state_q == ST_RUN) && last_dig) begin
            ovf <= dig_bo_msb ^ dig_bo;
        end
    end
`else
    logic unused_bo_msb;
    assign unused_bo_msb = dig_bo_msb;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor with an arithmetic reference model.
// Build with SERSUB_OVF_EN defined to also check ovf.
module tb_serial_subtractor #(
    parameter int W = 8,
    parameter int D = 2
);

    localparam int NDIG = W / D;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bo_in = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] diff;
    logic         bo_out;
`ifdef SERSUB_OVF_EN
    logic         ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor #(.WIDTH(W), .DIGIT(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bo_in     (bo_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bo_out    (bo_out)
`ifdef SERSUB_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0=idle, 1=busy, 2=result held; results from plain integer arithmetic.
    int           m_phase = 0;
    int           m_left  = 0;
    logic [W-1:0] m_diff = '0, p_diff;
    logic         m_bo = 1'b0, p_bo;
    logic         m_ovf = 1'b0, p_ovf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = 0;
            m_diff  = '0;
            m_bo    = 1'b0;
            m_ovf   = 1'b0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    int s;
                    p_diff  = W'(int'(a) - int'(b) - int'(bo_in));
                    p_bo    = (int'(a) < int'(b) + int'(bo_in));
                    s       = int'($signed(a)) - int'($signed(b)) - int'(bo_in);
                    p_ovf   = (s < -(1 << (W - 1))) || (s > (1 << (W - 1)) - 1);
                    m_left  = NDIG;
                    m_phase = 1;
                end
                1: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_diff  = p_diff;
                        m_bo    = p_bo;
                        m_ovf   = p_ovf;
                        m_phase = 2;
                    end
                end
                default: if (out_ready) m_phase = 0;
            endcase
        end
    end

    // Per-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        check("in_ready", in_ready, m_phase == 0);
        check("out_valid", out_valid, m_phase == 2);
        if (m_phase != 1) begin
            check("diff", diff, m_diff);
            check("bo_out", bo_out, m_bo);
`ifdef SERSUB_OVF_EN
            check("ovf", ovf, m_ovf);
`endif
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("in_ready_timeout", in_ready, 1'b1);
    endtask

    // Issue one op, measure accept-to-out_valid latency, hold the result one extra cycle, then release.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tbo,
                          input logic [W-1:0] ed, input logic ebo, input logic eovf);
        int lat = 0;
        wait_ready();
        a = ta; b = tb; bo_in = tbo; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = '0; b = '0; bo_in = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, NDIG);
        check("diff_literal", diff, ed);
        check("bo_literal", bo_out, ebo);
`ifdef SERSUB_OVF_EN
        check("ovf_literal", ovf, eovf);
`else
        if (eovf === 1'bx) check("ovf_unused", eovf, 1'b0);
`endif
        @(posedge clk); #1;
        check("done_hold", out_valid, 1'b1);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("back_to_idle", in_ready, 1'b1);
        check("idle_keeps_diff", diff, ed);
    endtask

    initial begin
        logic [W-1:0] held;
        #23;
        check("reset_diff", diff, 0);
        check("reset_bo", bo_out, 0);
        check("reset_out_valid", out_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_in_ready", in_ready, 1);

        run_op(8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        run_op(8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0);
        run_op(8'hA5, 8'h5A, 1'b0, 8'h4B, 1'b0, 1'b1);
        run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

        // Backpressure: result must hold while in_valid pulses are ignored.
        wait_ready();
        a = 8'hC8; b = 8'h64; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 50 && !out_valid; i++) begin
            @(posedge clk); #1;
        end
        held = diff;
        check("bp_diff", held, 8'h64);
        for (int i = 0; i < 5; i++) begin
            a = 8'h01; b = 8'h02; in_valid = (i % 2 == 0);
            @(posedge clk); #1;
            check("bp_valid", out_valid, 1'b1);
            check("bp_stable", diff, held);
            check("bp_in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_release", in_ready, 1'b1);
        check("bp_release_ov", out_valid, 1'b0);

        // Asynchronous reset in the middle of a run abandons the operation.
        a = 8'hFF; b = 8'h01; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_ov", out_valid, 0);
        check("rst_mid_diff", diff, 0);
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ready", in_ready, 1);
        run_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, expected finish");
        $fatal(1, "timeout");
    end

endmodule
